// File: rtl/cdc_arb_pkg.sv
// Shared definitions for the CDC request arbiter.
//   state_t  : arbiter FSM states (IDLE, WAIT_ACK)
//   MODE_*   : operation select carried in tx_mode
//   OPW      : operand width in bits
package cdc_arb_pkg;

  localparam int OPW = 4;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_MUL = 1'b1;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_ACK = 1'b1
  } state_t;

endpackage

// File: rtl/cdc_sync_2ff.sv
// Two-flop synchronizer for a single-bit level/toggle signal.
//   clk   in  destination clock
//   rst_n in  async active-low reset
//   i_d   in  asynchronous input
//   o_q   out synchronized output
module cdc_sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/rr_pick.sv
// Combinational round-robin picker. Searches from i_ptr+1 upward, wrapping,
// and returns the first set request.
//   i_req    in  request vector
//   i_ptr    in  index of the previous winner
//   o_onehot out one-hot winner (zero when no request)
//   o_idx    out winner index (zero when no request)
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_onehot,
  output logic [IW-1:0] o_idx
);

  logic          w_found;
  logic [IW-1:0] w_cand;

  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    w_found  = 1'b0;
    w_cand   = '0;
    for (int k = 1; k <= N; k++) begin
      w_cand = IW'((int'(i_ptr) + k) % N);
      if (!w_found && i_req[w_cand]) begin
        w_found          = 1'b1;
        o_onehot[w_cand] = 1'b1;
        o_idx            = w_cand;
      end
    end
  end

endmodule

// File: rtl/cdc_req_arbiter.sv
// Round-robin front end sharing one toggle-handshake CDC compute channel
// among NUM_REQ requesters. One transaction is outstanding at a time.
//
// Optional build macro: CDC_ARB_TIMEOUT_EN -- abort WAIT_ACK after
// TIMEOUT_CYC cycles without an acknowledge (sets err, still pulses done).
//
// Ports:
//   clk_1, rst_n     source clock, async active-low reset
//   req_valid/a/b/mode  per-requester request level and operands (packed)
//   ack_toggle       raw acknowledge toggle from the clk_2 side
//   grant            one-hot acceptance pulse (combinational, IDLE only)
//   done             one-hot completion pulse (registered)
//   busy             transaction accepted or outstanding
//   owner_id         current/last owner index
//   tx_toggle/a/b/mode  request toggle and operands held toward clk_2
//   err              sticky: spurious ack in IDLE or timeout
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | no transaction outstanding; grant winner if any request
// WAIT_ACK | toggle sent, operands frozen, waiting for ack toggle edge
module cdc_req_arbiter
  import cdc_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int ID_W        = $clog2(NUM_REQ),
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                   clk_1,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ*OPW-1:0] req_a,
  input  logic [NUM_REQ*OPW-1:0] req_b,
  input  logic [NUM_REQ-1:0]     req_mode,
  input  logic                   ack_toggle,
  output logic [NUM_REQ-1:0]     grant,
  output logic [NUM_REQ-1:0]     done,
  output logic                   busy,
  output logic [ID_W-1:0]        owner_id,
  output logic                   tx_toggle,
  output logic [OPW-1:0]         tx_a,
  output logic [OPW-1:0]         tx_b,
  output logic                   tx_mode,
  output logic                   err
);

  state_t               r_state;
  logic [ID_W-1:0]      r_ptr;
  logic [ID_W-1:0]      r_owner;
  logic [OPW-1:0]       r_tx_a;
  logic [OPW-1:0]       r_tx_b;
  logic                 r_tx_mode;
  logic                 r_tx_toggle;
  logic [NUM_REQ-1:0]   r_done;
  logic                 r_err;
  logic                 r_ack_q;

  logic                 w_ack_sync;
  logic                 w_ack_edge;
  logic [NUM_REQ-1:0]   w_win_oh;
  logic [ID_W-1:0]      w_win_idx;
  logic                 w_issue;
  logic                 w_timeout;
  logic                 w_finish;
  logic [OPW-1:0]       w_a_arr [NUM_REQ];
  logic [OPW-1:0]       w_b_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign w_a_arr[g] = req_a[g*OPW +: OPW];
    assign w_b_arr[g] = req_b[g*OPW +: OPW];
  end

  cdc_sync_2ff u_ack_sync (
    .clk   (clk_1),
    .rst_n (rst_n),
    .i_d   (ack_toggle),
    .o_q   (w_ack_sync)
  );

  assign w_ack_edge = w_ack_sync ^ r_ack_q;

  rr_pick #(
    .N  (NUM_REQ),
    .IW (ID_W)
  ) u_pick (
    .i_req    (req_valid),
    .i_ptr    (r_ptr),
    .o_onehot (w_win_oh),
    .o_idx    (w_win_idx)
  );

  assign w_issue = (r_state == IDLE) && (|req_valid);

`ifdef CDC_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  // Down-counter reloaded while idle; terminal count 0 is reached in the
  // TIMEOUT_CYC-th WAIT_ACK cycle.
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk_1 or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= CNT_W'(TIMEOUT_CYC - 1);
    end else if (r_state == WAIT_ACK && !w_finish) begin
      r_cnt <= r_cnt - 1'b1;
    end else begin
      r_cnt <= CNT_W'(TIMEOUT_CYC - 1);
    end
  end

  assign w_timeout = (r_state == WAIT_ACK) && (r_cnt == '0) && !w_ack_edge;
`else
  logic w_unused_timeout_cfg;
  assign w_unused_timeout_cfg = (TIMEOUT_CYC > 0);
  assign w_timeout = 1'b0;
`endif

  assign w_finish = w_ack_edge || w_timeout;

  always_ff @(posedge clk_1 or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_ptr       <= ID_W'(NUM_REQ - 1);
      r_owner     <= '0;
      r_tx_a      <= '0;
      r_tx_b      <= '0;
      r_tx_mode   <= 1'b0;
      r_tx_toggle <= 1'b0;
      r_done      <= '0;
      r_err       <= 1'b0;
      r_ack_q     <= 1'b0;
    end else begin
      r_ack_q <= w_ack_sync;
      r_done  <= '0;
      case (r_state)
        IDLE: begin
          if (w_ack_edge) begin
            r_err <= 1'b1;
          end
          if (w_issue) begin
            r_tx_a      <= w_a_arr[w_win_idx];
            r_tx_b      <= w_b_arr[w_win_idx];
            r_tx_mode   <= req_mode[w_win_idx];
            r_owner     <= w_win_idx;
            r_ptr       <= w_win_idx;
            r_tx_toggle <= ~r_tx_toggle;
            r_state     <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (w_finish) begin
            r_done[r_owner] <= 1'b1;
            r_state         <= IDLE;
            if (w_timeout) begin
              r_err <= 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign grant     = w_issue ? w_win_oh : '0;
  // Busy covers the accepting cycle too, so back-to-back issues show no gap.
  assign busy      = (r_state == WAIT_ACK) || w_issue;
  assign done      = r_done;
  assign owner_id  = r_owner;
  assign tx_toggle = r_tx_toggle;
  assign tx_a      = r_tx_a;
  assign tx_b      = r_tx_b;
  assign tx_mode   = r_tx_mode;
  assign err       = r_err;

endmodule
